// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Optional feature macro: DMEM_ERR_CHECK_EN (access error detection).
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LANE_W     = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic int widx_w(input int addr_w);
      return addr_w - LANE_W;
   endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select with sign/zero extension.
// Optional feature macro: DMEM_ERR_CHECK_EN (not used here).
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [31:0]       word,
   input  logic [LANE_W-1:0] lane,
   input  logic [2:0]        funct3,
   output logic [31:0]       data
);

   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;

   assign shifted = word >> {lane, 3'b000};
   assign b       = shifted[7:0];
   assign h       = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = word;
      unique case (1'b1)
         (funct3 == F3_B):  data = {{24{b[7]}}, b};
         (funct3 == F3_BU): data = {24'd0, b};
         (funct3 == F3_H):  data = {{16{h[15]}}, h};
         (funct3 == F3_HU): data = {16'd0, h};
         default:           data = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port, fixed latency.
// Optional feature macro: DMEM_ERR_CHECK_EN (access error detection).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [3:0]        req_wstrb_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int IDX_W  = widx_w(ADDR_W);
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t state, state_nx;
   logic [3:0]  cnt;
   logic        accept, commit;

   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0] mem [DEPTH];

   logic [IDX_W-1:0]  widx;
   logic [LANE_W-1:0] lane, lane_eff;
   logic [RAM_AW-1:0] ridx;
   logic [2:0]        f3_eff;
   logic [1:0]        size;
   logic              f3_bad, err;
   logic [31:0]       word, ld_data, st_data;

   always_comb begin
      state_nx    = state;
      req_ready_o = 1'b0;
      accept      = 1'b0;
      commit      = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept   = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               commit   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            cnt     <= CNT_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            rdata_q <= (we_q || err) ? 32'd0 : ld_data;
            err_q   <= err;
         end
      end
   end

   assign rsp_valid_o = (state == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   assign widx = addr_q[ADDR_W-1:LANE_W];
   assign lane = addr_q[LANE_W-1:0];
   assign ridx = RAM_AW'(32'(widx) % 32'(DEPTH));

   always_comb begin
      if (we_q) f3_bad = (f3_q > F3_W);
      else      f3_bad = f3_q inside {3'b011, 3'b110, 3'b111};
   end

   assign f3_eff = f3_bad ? F3_W : f3_q;
   assign size   = f3_eff[1:0];

   // Misaligned accesses are realigned; only reachable when not flagged.
   always_comb begin
      lane_eff = lane;
      if (size == 2'b01) lane_eff = {lane[1], 1'b0};
      if (size == 2'b10) lane_eff = 2'b00;
   end

`ifdef DMEM_ERR_CHECK_EN
   logic mis, oor;
   assign mis = ((size == 2'b01) && lane[0]) ||
                ((size == 2'b10) && (lane != 2'b00));
   assign oor = (32'(widx) >= 32'(DEPTH));
   assign err = f3_bad || mis || oor;
`else
   assign err = 1'b0;
`endif

   assign word    = mem[ridx];
   assign st_data = wdata_q << {lane_eff, 3'b000};

   dmem_load_ext u_load_ext (
      .word   (word),
      .lane   (lane_eff),
      .funct3 (f3_eff),
      .data   (ld_data)
   );

   always_ff @(posedge clock_i) begin
      if (commit && we_q && !err) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (wstrb_q[k]) mem[ridx][8*k +: 8] <= st_data[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (ADDR_W=13).
// Expectations follow DMEM_ERR_CHECK_EN when it is defined.
module tb_dmem_responder;

   localparam int ADDR_W  = 13;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

`ifdef DMEM_ERR_CHECK_EN
   localparam bit ERRC = 1'b1;
`else
   localparam bit ERRC = 1'b0;
`endif

   logic              clock_i = 1'b0;
   logic              reset_ni;
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [2:0]        req_funct3_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic [3:0]        req_wstrb_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock_i = ~clock_i;

   dmem_responder #(
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_wstrb_i  (req_wstrb_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o)
   );

   typedef struct {
      logic              we;
      logic [2:0]        f3;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wd;
      logic [3:0]        ws;
      logic [31:0]       rd;
      logic              er;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [2:0] f3,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] rd,
                      input logic er);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wd = wd;
      v.ws = ws; v.rd = rd; v.er = er;
      vq.push_back(v);
   endtask

   task automatic drive(input logic we, input logic [2:0] f3,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = a;
      req_wdata_i  = wd;
      req_wstrb_i  = ws;
   endtask

   task automatic scramble();
      req_valid_i  = 1'b0;
      req_we_i     = ~req_we_i;
      req_funct3_i = ~req_funct3_i;
      req_addr_i   = ~req_addr_i;
      req_wdata_i  = ~req_wdata_i;
      req_wstrb_i  = ~req_wstrb_i;
   endtask

   task automatic xact(input logic we, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       input logic [3:0] ws,
                       output logic [31:0] rd, output logic er);
      int n;
      bit got;
      rsp_ready_i = 1'b1;
      @(negedge clock_i);
      chk("ready_before_req", req_ready_o, 1);
      drive(we, f3, a, wd, ws);
      @(posedge clock_i);
      #1;
      scramble();
      chk("ready_in_wait", req_ready_o, 0);
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         if (rsp_valid_o) got = 1'b1;
         else begin
            @(posedge clock_i);
            #1;
            n++;
         end
      end
      chk("rsp_timeout", got, 1);
      chk("latency", n, LATENCY);
      rd = rsp_rdata_o;
      er = rsp_err_o;
      @(posedge clock_i);
      #1;
      chk("rsp_consumed", rsp_valid_o, 0);
      chk("ready_after_rsp", req_ready_o, 1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          n;

      reset_ni    = 1'b0;
      rsp_ready_i = 1'b1;
      drive(1'b1, 3'b010, 13'h010, 32'h1, 4'hF);
      repeat (3) begin
         @(negedge clock_i);
         chk("rst_ready", req_ready_o, 1);
         chk("rst_valid", rsp_valid_o, 0);
         chk("rst_rdata", rsp_rdata_o, 0);
         chk("rst_err", rsp_err_o, 0);
      end
      req_valid_i = 1'b0;
      reset_ni    = 1'b1;
      @(posedge clock_i);
      #1;
      chk("post_rst_valid", rsp_valid_o, 0);

      add(1, 3'b010, 13'h010, 32'hDEADBEEF, 4'hF, 32'h0, 0);
      add(0, 3'b010, 13'h010, 32'h0, 4'h0, 32'hDEADBEEF, 0);
      add(1, 3'b000, 13'h013, 32'h00000080, 4'b1000, 32'h0, 0);
      add(0, 3'b010, 13'h010, 32'h0, 4'h0, 32'h80ADBEEF, 0);
      add(0, 3'b000, 13'h013, 32'h0, 4'h0, 32'hFFFFFF80, 0);
      add(0, 3'b100, 13'h013, 32'h0, 4'h0, 32'h00000080, 0);
      add(0, 3'b101, 13'h012, 32'h0, 4'h0, 32'h000080AD, 0);
      add(0, 3'b001, 13'h012, 32'h0, 4'h0, 32'hFFFF80AD, 0);
      add(0, 3'b001, 13'h010, 32'h0, 4'h0, 32'hFFFFBEEF, 0);
      add(0, 3'b000, 13'h011, 32'h0, 4'h0, 32'hFFFFFFBE, 0);
      add(0, 3'b100, 13'h010, 32'h0, 4'h0, 32'h000000EF, 0);
      add(1, 3'b010, 13'h014, 32'hAABBCCDD, 4'hF, 32'h0, 0);
      add(1, 3'b001, 13'h016, 32'h00001234, 4'b1100, 32'h0, 0);
      add(0, 3'b010, 13'h014, 32'h0, 4'h0, 32'h1234CCDD, 0);
      add(0, 3'b101, 13'h014, 32'h0, 4'h0, 32'h0000CCDD, 0);
      add(1, 3'b010, 13'h018, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
      add(1, 3'b010, 13'h018, 32'h11223344, 4'b0101, 32'h0, 0);
      add(0, 3'b010, 13'h018, 32'h0, 4'h0, 32'hFF22FF44, 0);
      add(0, 3'b010, 13'h011, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h80ADBEEF, ERRC);
      add(1, 3'b010, 13'h004, 32'hCAFEF00D, 4'hF, 32'h0, 0);
      add(1, 3'b001, 13'h005, 32'h00005555, 4'b0110, 32'h0, ERRC);
      add(0, 3'b010, 13'h004, 32'h0, 4'h0,
          ERRC ? 32'hCAFEF00D : 32'hCA00550D, 0);
      add(1, 3'b010, 13'h000, 32'h0BADF00D, 4'hF, 32'h0, 0);
      add(0, 3'b010, 13'h1000, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h0BADF00D, ERRC);
      add(0, 3'b011, 13'h010, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h80ADBEEF, ERRC);
      add(1, 3'b010, 13'h01C, 32'h00000000, 4'hF, 32'h0, 0);
      add(1, 3'b011, 13'h01C, 32'h87654321, 4'hF, 32'h0, ERRC);
      add(0, 3'b010, 13'h01C, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h87654321, 0);
      add(0, 3'b101, 13'h013, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h000080AD, ERRC);
      add(0, 3'b110, 13'h012, 32'h0, 4'h0,
          ERRC ? 32'h0 : 32'h80ADBEEF, ERRC);

      for (int i = 0; i < vq.size(); i++) begin
         xact(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wd, vq[i].ws, rd, er);
         chk($sformatf("vec%0d_rdata", i), rd, vq[i].rd);
         chk($sformatf("vec%0d_err", i), er, vq[i].er);
      end

      // Backpressure: response held, new requests refused.
      rsp_ready_i = 1'b0;
      @(negedge clock_i);
      drive(1'b0, 3'b010, 13'h010, 32'h0, 4'h0);
      @(posedge clock_i);
      #1;
      req_valid_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 20) begin
         @(posedge clock_i);
         #1;
         n++;
      end
      chk("bp_latency", n, LATENCY);
      drive(1'b1, 3'b010, 13'h010, 32'h0, 4'hF);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", rsp_valid_o, 1);
         chk("bp_rdata", rsp_rdata_o, 32'h80ADBEEF);
         chk("bp_ready", req_ready_o, 0);
         @(posedge clock_i);
         #1;
      end
      @(negedge clock_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clock_i);
      #1;
      chk("bp_release_valid", rsp_valid_o, 0);
      chk("bp_release_ready", req_ready_o, 1);
      xact(1'b0, 3'b010, 13'h010, 32'h0, 4'h0, rd, er);
      chk("bp_store_dropped", rd, 32'h80ADBEEF);

      // Reset while a store is still waiting to commit.
      xact(1'b1, 3'b010, 13'h020, 32'h11111111, 4'hF, rd, er);
      @(negedge clock_i);
      drive(1'b1, 3'b010, 13'h020, 32'h12345678, 4'hF);
      @(posedge clock_i);
      #1;
      req_valid_i = 1'b0;
      @(posedge clock_i);
      #1;
      reset_ni = 1'b0;
      #1;
      chk("rst_wait_ready", req_ready_o, 1);
      repeat (2) begin
         @(posedge clock_i);
         #1;
         chk("rst_wait_valid", rsp_valid_o, 0);
      end
      @(negedge clock_i);
      reset_ni = 1'b1;
      xact(1'b0, 3'b010, 13'h020, 32'h0, 4'h0, rd, er);
      chk("rst_wait_old", rd, 32'h11111111);

      // Reset during RESP: store already committed survives.
      rsp_ready_i = 1'b0;
      @(negedge clock_i);
      drive(1'b1, 3'b010, 13'h024, 32'h5A5A5A5A, 4'hF);
      @(posedge clock_i);
      #1;
      req_valid_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 20) begin
         @(posedge clock_i);
         #1;
         n++;
      end
      chk("rst_resp_seen", rsp_valid_o, 1);
      reset_ni = 1'b0;
      #1;
      chk("rst_resp_drop", rsp_valid_o, 0);
      @(negedge clock_i);
      reset_ni = 1'b1;
      xact(1'b0, 3'b010, 13'h024, 32'h0, 4'h0, rd, er);
      chk("rst_resp_kept", rd, 32'h5A5A5A5A);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory-side) end of the core's data-memory load/store interface.
- Accepts one load or store request per valid/ready handshake and performs it on an internal word-organised RAM after a programmable latency.
- Returns one response per request: load data or store acknowledge.
- Sits between the core's load/store path and on-chip data storage, replacing the core's single-cycle zero-wait memory for multi-cycle memory models.

Parameters:
- ADDR_W, 12, byte-address width; requires DEPTH*4 <= 2^ADDR_W.
- DEPTH, 1024, number of 32-bit words in the RAM.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clock_i  in  1  clock; all state updates on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I load/store funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, unshifted, LSB-aligned like rs2.
- req_wstrb_i  in  4  byte-lane write enables, already address-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err_o  out  1  access error: misaligned, out of range, or illegal funct3.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE, counter=0. RAM contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Accept = req_valid_i & req_ready_o at a rising edge.
  - On accept: capture we, funct3, addr, wdata, wstrb into registers; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready_o=0.
  - While counter != 0, decrement each cycle.
  - On the edge where counter==0: perform the access from the captured registers, register the result, go to RESP.
  - rsp_valid_o therefore rises LATENCY edges after the accept edge.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable.
  - req_ready_o=0, so requests never overlap.
  - On rsp_valid_o & rsp_ready_i: clear rsp_valid_o and go to IDLE.
  - A new request is accepted no earlier than the next cycle.
  - Minimum request period is LATENCY+2 cycles.
- Word index is addr[ADDR_W-1:2]; lane is addr[1:0].
- Store:
  - Lane data = wdata << (8*lane).
  - Each byte k is written only where wstrb[k]=1; other bytes are unchanged.
  - rsp_rdata_o=0.
- Load lane extraction:
  - LB/LBU take byte[lane].
  - LH/LHU take halfword[lane[1]].
  - LW takes the whole word.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Errors, checked on the captured request:
  - Halfword access with lane[0]=1.
  - Word access with lane != 0.
  - Word index >= DEPTH.
  - Load funct3 in {011, 110, 111}, or store funct3 > 010.
- On error: no RAM write, rsp_rdata_o=0, rsp_err_o=1. The response is still delivered and the handshake is unchanged.
- Request inputs are sampled only at the accept edge; changes afterwards are ignored.
- rsp_ready_i held high in advance: the response is consumed on the first RESP cycle.
- Reset mid-operation:
  - Asynchronous return to IDLE; the pending response is dropped.
  - A store still in WAIT is never written.
  - A store already committed stays committed.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: error detection exactly as above.
- Undefined:
  - rsp_err_o is tied to 0.
  - Misaligned halfword and word accesses force the low address bits to zero (lane &= ~1 for halfword, lane = 0 for word) and are then performed.
  - Out-of-range word index wraps modulo DEPTH.
  - Illegal load funct3 behaves as LW; illegal store funct3 behaves as SW.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding typedef: IDLE/WAIT/RESP.
  - Lane and word-index width helper constants.
- One sub-module, dmem_load_ext: combinational lane select plus sign/zero extension.
  - Inputs: word[31:0], lane[1:0], funct3.
  - Output: data[31:0].
  - Instantiated once, feeding the response register.

Test Plan:
- Reset/idle: hold reset_ni=0 with req_valid_i=1 -> req_ready_o=1, rsp_valid_o=0; no accept until reset_ni=1.
- Latency: LATENCY=2; SW 0xDEADBEEF to addr 0x010, then LW 0x010 -> each rsp_valid_o rises exactly 2 edges after its accept; LW returns 0xDEADBEEF, err=0.
- Byte stores and loads after word 0x010 = 0xDEADBEEF:
  - SB 0x80 at 0x013 with wstrb=1000 -> word = 0x80ADBEEF.
  - LB 0x013 -> 0xFFFFFF80.
  - LBU 0x013 -> 0x00000080.
  - LHU 0x012 -> 0x000080AD.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o -> rdata stable and req_ready_o=0 throughout; release -> IDLE on the next edge.
- Errors (DMEM_ERR_CHECK_EN defined): LW at 0x011 -> err=1, rdata=0; SH at 0x005 -> err=1 and word 1 unchanged; LW at 0x1000 with ADDR_W=13, DEPTH=1024 -> err=1.
- Reset in WAIT: SW 0x12345678 to 0x020, assert reset_ni before the commit edge -> no response; a later LW 0x020 returns the old contents.
